// File: rtl/mult_pkg.sv
// Shared types and constants for the round-robin multiplier sequencer.
package mult_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_SUB,
    S_SHIFT_LAST,
    S_DONE
  } mult_state_t;

endpackage

// File: rtl/mult_rr_sequencer_arb.sv
// Two-request round-robin picker; purely combinational one-hot winner.
module rr_arb2
  import mult_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // last holds the index of the requester served most recently
  always_comb begin
    win = '0;
    unique case (req)
      2'b01:   win[REQ0] = 1'b1;
      2'b10:   win[REQ1] = 1'b1;
      2'b11:   if (last) win[REQ0] = 1'b1; else win[REQ1] = 1'b1;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/mult_rr_sequencer.sv
// Sequences the shared shift-add multiplier datapath for two round-robin requesters.
// Optional MULT_SKIP_ZERO_EN: a zero multiplier bit shifts during ADD and skips SHIFT.
module mult_rr_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0]       Req,
  input  logic [WIDTH-1:0] OpS_0,
  input  logic [WIDTH-1:0] OpS_1,
  input  logic [WIDTH-1:0] OpB_0,
  input  logic [WIDTH-1:0] OpB_1,
  input  logic             M,
  output logic [1:0]       Gnt,
  output logic [1:0]       Done,
  output logic             Busy,
  output logic [WIDTH-1:0] S_out,
  output logic [WIDTH-1:0] B_out,
  output logic             ClrA_LdB,
  output logic             Shift,
  output logic             Add,
  output logic             Sub
);

  localparam int unsigned CW = $clog2(WIDTH);

  mult_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    owner;
  logic [1:0]    win;
  logic          last;
  logic          term;

  rr_arb2 u_arb (
    .req  (Req),
    .last (last),
    .win  (win)
  );

  assign term = (cnt == CW'(WIDTH - 2));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      owner <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && |Req) begin
        owner <= win;
      end else if (state == S_DONE) begin
        owner <= '0;
        last  <= owner[REQ1];
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ClrA_LdB = 1'b0;
    Shift    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|Req) state_nx = S_LOAD;
      end
      S_LOAD: begin
        ClrA_LdB = 1'b1;
        cnt_nx   = '0;
        state_nx = S_ADD;
      end
      S_ADD: begin
`ifdef MULT_SKIP_ZERO_EN
        // zero bit: fold the shift into this cycle and count the iteration here
        if (!M) begin
          Shift    = 1'b1;
          cnt_nx   = cnt + CW'(1);
          state_nx = term ? S_SUB : S_ADD;
        end else begin
          Add      = 1'b1;
          state_nx = S_SHIFT;
        end
`else
        Add      = M;
        state_nx = S_SHIFT;
`endif
      end
      S_SHIFT: begin
        Shift    = 1'b1;
        cnt_nx   = cnt + CW'(1);
        state_nx = term ? S_SUB : S_ADD;
      end
      S_SUB: begin
        Sub      = M;
        state_nx = S_SHIFT_LAST;
      end
      S_SHIFT_LAST: begin
        Shift    = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // owner is cleared outside LOAD..DONE, so the muxes and Gnt read zero when idle
  assign Gnt   = owner;
  assign Done  = (state == S_DONE) ? owner : '0;
  assign Busy  = (state != S_IDLE);
  assign S_out = owner[REQ1] ? OpS_1 : (owner[REQ0] ? OpS_0 : '0);
  assign B_out = owner[REQ1] ? OpB_1 : (owner[REQ0] ? OpB_0 : '0);

endmodule
